jtag_probe_channel_mux: RTL and testbench

Core-clock-side channel multiplexer that sits behind the JTAG-to-core probe's core_clock data port pair. It lets one JTAG probe serve NUM_CHANNELS independent clients.
- Host-to-FPGA: words carry a channel tag in the MSBs and are steered to the addressed client.
- FPGA-to-host: client words are round-robin arbitrated and tagged.
- Also adds stall timeout and drop accounting.

---
 rtl/jtag_probe_pkg.sv | 24 ++
 rtl/jtag_probe_channel_mux_if.sv | 41 ++++
 rtl/probe_rr_arbiter.sv | 33 +++
 rtl/jtag_probe_channel_mux.sv | 139 +++++++++++++
 tb/tb_jtag_probe_channel_mux.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/jtag_probe_pkg.sv
// rtl/jtag_probe_pkg.sv - shared sizing and tag-field helpers for the probe channel mux
package jtag_probe_pkg;

    localparam int MIN_CHANNELS = 2;
    localparam int MAX_CHANNELS = 16;

    function automatic bit num_channels_ok(int n);
        return (n >= MIN_CHANNELS) && (n <= MAX_CHANNELS);
    endfunction

    // Tag width never drops below one bit, even for two channels.
    function automatic int ch_bits_f(int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int tag_extract(logic [63:0] word, int dat_w, int ch_b);
        return int'((word >> (dat_w - ch_b)) & ((64'd1 << ch_b) - 64'd1));
    endfunction

    function automatic logic [63:0] tag_insert(int tag, logic [63:0] payload, int pw);
        return (64'(tag) << pw) | payload;
    endfunction

endpackage

// File: rtl/jtag_probe_channel_mux_if.sv
// rtl/jtag_probe_channel_mux_if.sv - probe-side and client-side handshake bundle
interface jtag_probe_channel_mux_if
    import jtag_probe_pkg::*;
#(
    parameter int DAT_WIDTH    = 16,
    parameter int NUM_CHANNELS = 4,
    parameter int CNT_WIDTH    = 8
) ();

    localparam int CH_BITS = ch_bits_f(NUM_CHANNELS);
    localparam int PW      = DAT_WIDTH - CH_BITS;

    logic [DAT_WIDTH-1:0]       from_host_dat;
    logic                       from_host_valid;
    logic                       from_host_ready;
    logic [DAT_WIDTH-1:0]       to_host_dat;
    logic                       to_host_valid;
    logic                       to_host_ready;
    logic [NUM_CHANNELS*PW-1:0] ch_rx_dat;
    logic [NUM_CHANNELS-1:0]    ch_rx_valid;
    logic [NUM_CHANNELS-1:0]    ch_rx_ready;
    logic [NUM_CHANNELS*PW-1:0] ch_tx_dat;
    logic [NUM_CHANNELS-1:0]    ch_tx_valid;
    logic [NUM_CHANNELS-1:0]    ch_tx_ready;
    logic [CNT_WIDTH-1:0]       drop_count;

    modport master (
        output from_host_dat, from_host_valid, to_host_ready,
               ch_rx_ready, ch_tx_dat, ch_tx_valid,
        input  from_host_ready, to_host_dat, to_host_valid,
               ch_rx_dat, ch_rx_valid, ch_tx_ready, drop_count
    );

    modport slave (
        input  from_host_dat, from_host_valid, to_host_ready,
               ch_rx_ready, ch_tx_dat, ch_tx_valid,
        output from_host_ready, to_host_dat, to_host_valid,
               ch_rx_dat, ch_rx_valid, ch_tx_ready, drop_count
    );

endinterface

// File: rtl/probe_rr_arbiter.sv
// rtl/probe_rr_arbiter.sv - round-robin grant starting after the last granted index
module probe_rr_arbiter
    import jtag_probe_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = ch_bits_f(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    logic [IW-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(ptr_i) + i) % N);
            if (!found_o && req_i[cand]) begin
                found_o       = 1'b1;
                idx_o         = cand;
                grant_o[cand] = advance_i;
            end
        end
    end

endmodule

// File: rtl/jtag_probe_channel_mux.sv
// rtl/jtag_probe_channel_mux.sv - tag-steered host->client demux and round-robin client->host mux
module jtag_probe_channel_mux
    import jtag_probe_pkg::*;
#(
    parameter int DAT_WIDTH    = 16,
    parameter int NUM_CHANNELS = 4,
    parameter int TIMEOUT      = 8,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                      core_clock,
    input  logic                      clrn,
    jtag_probe_channel_mux_if.slave   bus
);

    localparam int CH_BITS = ch_bits_f(NUM_CHANNELS);
    localparam int PW      = DAT_WIDTH - CH_BITS;
    localparam int TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    if (!num_channels_ok(NUM_CHANNELS)) begin : g_bad_channels
        $error("NUM_CHANNELS out of range");
    end

    logic                       rx_full_q, rx_full_d;
    logic [CH_BITS-1:0]         rx_tag_q, rx_tag_d;
    logic [NUM_CHANNELS*PW-1:0] rx_dat_q, rx_dat_d;
    logic [TW-1:0]              wait_q, wait_d;
    logic [CNT_WIDTH-1:0]       drop_q, drop_d;
    logic [CH_BITS-1:0]         in_tag;
    logic                       in_tag_ok, rx_accept, rx_xfer, rx_timeout, drop_evt;
    logic [NUM_CHANNELS-1:0]    rx_valid;

    assign in_tag     = CH_BITS'(tag_extract(64'(bus.from_host_dat), DAT_WIDTH, CH_BITS));
    assign in_tag_ok  = int'(in_tag) < NUM_CHANNELS;
    assign rx_accept  = bus.from_host_valid & ~rx_full_q;
    assign rx_xfer    = rx_full_q & bus.ch_rx_ready[rx_tag_q];
    // A client transfer on the expiry edge takes priority over the drop.
    assign rx_timeout = (TIMEOUT > 0) && rx_full_q && !rx_xfer && (wait_q == TW'(TIMEOUT - 1));

    always_comb begin
        rx_full_d = rx_full_q;
        rx_tag_d  = rx_tag_q;
        rx_dat_d  = rx_dat_q;
        wait_d    = wait_q;
        drop_evt  = 1'b0;
        if (rx_accept) begin
            wait_d = '0;
            if (in_tag_ok) begin
                rx_full_d = 1'b1;
                rx_tag_d  = in_tag;
                rx_dat_d[int'(in_tag)*PW +: PW] = bus.from_host_dat[PW-1:0];
            end else begin
                drop_evt = 1'b1;
            end
        end else if (rx_full_q) begin
            if (rx_xfer) begin
                rx_full_d = 1'b0;
            end else if (rx_timeout) begin
                rx_full_d = 1'b0;
                drop_evt  = 1'b1;
            end else begin
                wait_d = wait_q + TW'(1);
            end
        end
        drop_d = (drop_evt && (drop_q != '1)) ? drop_q + CNT_WIDTH'(1) : drop_q;
    end

    always_comb begin
        rx_valid = '0;
        if (rx_full_q) rx_valid[rx_tag_q] = 1'b1;
    end

    logic                 tx_valid_q, tx_valid_d;
    logic [DAT_WIDTH-1:0] tx_dat_q, tx_dat_d;
    logic [CH_BITS-1:0]   ptr_q, ptr_d, gnt_idx;
    logic [NUM_CHANNELS-1:0] gnt;
    logic                 tx_load, gnt_found;

    assign tx_load = ~tx_valid_q | bus.to_host_ready;

    probe_rr_arbiter #(
        .N  (NUM_CHANNELS),
        .IW (CH_BITS)
    ) u_arb (
        .req_i     (bus.ch_tx_valid),
        .advance_i (tx_load & clrn),
        .ptr_i     (ptr_q),
        .grant_o   (gnt),
        .idx_o     (gnt_idx),
        .found_o   (gnt_found)
    );

    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_dat_d   = tx_dat_q;
        ptr_d      = ptr_q;
        if (tx_load) begin
            if (gnt_found) begin
                tx_valid_d = 1'b1;
                ptr_d      = gnt_idx;
                tx_dat_d   = DAT_WIDTH'(tag_insert(int'(gnt_idx),
                                 64'(bus.ch_tx_dat[int'(gnt_idx)*PW +: PW]), PW));
            end else begin
                tx_valid_d = 1'b0;
            end
        end
    end

    // Pointer resets to the last channel so the first grant lands on channel 0.
    always_ff @(posedge core_clock or negedge clrn) begin
        if (!clrn) begin
            rx_full_q  <= 1'b0;
            rx_tag_q   <= '0;
            rx_dat_q   <= '0;
            wait_q     <= '0;
            drop_q     <= '0;
            tx_valid_q <= 1'b0;
            tx_dat_q   <= '0;
            ptr_q      <= CH_BITS'(NUM_CHANNELS - 1);
        end else begin
            rx_full_q  <= rx_full_d;
            rx_tag_q   <= rx_tag_d;
            rx_dat_q   <= rx_dat_d;
            wait_q     <= wait_d;
            drop_q     <= drop_d;
            tx_valid_q <= tx_valid_d;
            tx_dat_q   <= tx_dat_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.from_host_ready = ~rx_full_q;
    assign bus.ch_rx_valid     = rx_valid;
    assign bus.ch_rx_dat       = rx_dat_q;
    assign bus.to_host_valid   = tx_valid_q;
    assign bus.to_host_dat     = tx_dat_q;
    assign bus.ch_tx_ready     = gnt;
    assign bus.drop_count      = drop_q;

endmodule

// File: tb/tb_jtag_probe_channel_mux.sv
// tb/tb_jtag_probe_channel_mux.sv - directed self-checking bench for jtag_probe_channel_mux
module tb_jtag_probe_channel_mux;

    logic core_clock = 1'b0;
    logic clrn       = 1'b0;
    int   errors     = 0;
    int   checks     = 0;

    always #5 core_clock = ~core_clock;

    jtag_probe_channel_mux_if #(.DAT_WIDTH(16), .NUM_CHANNELS(4), .CNT_WIDTH(8)) b4 ();
    jtag_probe_channel_mux_if #(.DAT_WIDTH(16), .NUM_CHANNELS(3), .CNT_WIDTH(8)) b3 ();

    jtag_probe_channel_mux #(.DAT_WIDTH(16), .NUM_CHANNELS(4), .TIMEOUT(8), .CNT_WIDTH(8)) u_dut4 (
        .core_clock (core_clock),
        .clrn       (clrn),
        .bus        (b4.slave)
    );

    jtag_probe_channel_mux #(.DAT_WIDTH(16), .NUM_CHANNELS(3), .TIMEOUT(8), .CNT_WIDTH(8)) u_dut3 (
        .core_clock (core_clock),
        .clrn       (clrn),
        .bus        (b3.slave)
    );

    typedef struct {
        logic [15:0] hdat;
        logic        hvalid;
        logic [3:0]  rxrdy;
        logic [3:0]  exp_rxv;
        logic        exp_hrdy;
        logic [55:0] exp_dat;
        logic [7:0]  exp_drop;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge core_clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] arb_exp[5];

        vecs[0] = '{16'h8123, 1'b1, 4'b0100, 4'b0100, 1'b0, {14'h0, 14'h0123, 14'h0, 14'h0}, 8'h0};
        vecs[1] = '{16'h8123, 1'b0, 4'b0100, 4'b0000, 1'b1, {14'h0, 14'h0123, 14'h0, 14'h0}, 8'h0};
        vecs[2] = '{16'h4055, 1'b1, 4'b0010, 4'b0010, 1'b0, {14'h0, 14'h0123, 14'h0055, 14'h0}, 8'h0};
        vecs[3] = '{16'hC3FF, 1'b1, 4'b0010, 4'b0000, 1'b1, {14'h0, 14'h0123, 14'h0055, 14'h0}, 8'h0};
        vecs[4] = '{16'hC3FF, 1'b1, 4'b0000, 4'b1000, 1'b0, {14'h03FF, 14'h0123, 14'h0055, 14'h0}, 8'h0};
        vecs[5] = '{16'hC3FF, 1'b0, 4'b1000, 4'b0000, 1'b1, {14'h03FF, 14'h0123, 14'h0055, 14'h0}, 8'h0};
        vecs[6] = '{16'h0007, 1'b1, 4'b0001, 4'b0001, 1'b0, {14'h03FF, 14'h0123, 14'h0055, 14'h0007}, 8'h0};
        vecs[7] = '{16'h0007, 1'b0, 4'b0001, 4'b0000, 1'b1, {14'h03FF, 14'h0123, 14'h0055, 14'h0007}, 8'h0};
        arb_exp = '{16'h00AA, 16'h40AB, 16'h80AC, 16'hC0AD, 16'h00AA};

        b4.from_host_dat = '0; b4.from_host_valid = 1'b0; b4.to_host_ready = 1'b0;
        b4.ch_rx_ready = '0; b4.ch_tx_valid = '0;
        b4.ch_tx_dat = {14'h0AD, 14'h0AC, 14'h0AB, 14'h0AA};
        b3.from_host_dat = '0; b3.from_host_valid = 1'b0; b3.to_host_ready = 1'b0;
        b3.ch_rx_ready = '0; b3.ch_tx_valid = '0; b3.ch_tx_dat = '0;

        // Reset behaviour
        b4.ch_tx_valid = 4'hF;
        #2;
        chk("reset tx_ready gated", 64'(b4.ch_tx_ready), 64'h0);
        b4.ch_tx_valid = 4'h0;
        #20 clrn = 1'b1;
        step();
        chk("reset from_host_ready", 64'(b4.from_host_ready), 64'h1);
        chk("reset ch_rx_valid", 64'(b4.ch_rx_valid), 64'h0);
        chk("reset ch_rx_dat", 64'(b4.ch_rx_dat), 64'h0);
        chk("reset to_host_valid", 64'(b4.to_host_valid), 64'h0);
        chk("reset to_host_dat", 64'(b4.to_host_dat), 64'h0);
        chk("reset drop_count", 64'(b4.drop_count), 64'h0);

        // Table-driven rx path
        for (int i = 0; i < 8; i++) begin
            b4.from_host_dat   = vecs[i].hdat;
            b4.from_host_valid = vecs[i].hvalid;
            b4.ch_rx_ready     = vecs[i].rxrdy;
            step();
            chk($sformatf("vec%0d ch_rx_valid", i), 64'(b4.ch_rx_valid), 64'(vecs[i].exp_rxv));
            chk($sformatf("vec%0d from_host_ready", i), 64'(b4.from_host_ready), 64'(vecs[i].exp_hrdy));
            chk($sformatf("vec%0d ch_rx_dat", i), 64'(b4.ch_rx_dat), 64'(vecs[i].exp_dat));
            chk($sformatf("vec%0d drop_count", i), 64'(b4.drop_count), 64'(vecs[i].exp_drop));
        end
        b4.from_host_valid = 1'b0;
        b4.ch_rx_ready     = '0;

        // Timeout: word held 8 cycles then dropped
        b4.from_host_dat = 16'h8123; b4.from_host_valid = 1'b1;
        step();
        b4.from_host_valid = 1'b0;
        n = 0;
        while (b4.ch_rx_valid[2] && n < 20) begin
            n++;
            step();
        end
        chk("timeout valid cycles", 64'(n), 64'd8);
        chk("timeout drop_count", 64'(b4.drop_count), 64'd1);
        chk("timeout from_host_ready", 64'(b4.from_host_ready), 64'h1);

        // Ready on the final cycle delivers instead of dropping
        b4.from_host_valid = 1'b1;
        step();
        b4.from_host_valid = 1'b0;
        repeat (7) step();
        chk("last-cycle still held", 64'(b4.ch_rx_valid), 64'b0100);
        b4.ch_rx_ready = 4'b0100;
        step();
        b4.ch_rx_ready = '0;
        chk("last-cycle delivered", 64'(b4.ch_rx_valid), 64'h0);
        chk("last-cycle no drop", 64'(b4.drop_count), 64'd1);

        // Invalid tag on the 3-channel instance, then saturation
        b3.from_host_dat = 16'hC001; b3.from_host_valid = 1'b1;
        #1;
        chk("badtag from_host_ready before", 64'(b3.from_host_ready), 64'h1);
        step();
        chk("badtag ch_rx_valid", 64'(b3.ch_rx_valid), 64'h0);
        chk("badtag drop_count", 64'(b3.drop_count), 64'd1);
        chk("badtag from_host_ready after", 64'(b3.from_host_ready), 64'h1);
        repeat (299) step();
        b3.from_host_valid = 1'b0;
        chk("saturated drop_count", 64'(b3.drop_count), 64'hFF);
        chk("saturated ch_rx_valid", 64'(b3.ch_rx_valid), 64'h0);

        // Round-robin arbitration, back to back
        b4.ch_tx_valid = 4'hF; b4.to_host_ready = 1'b1;
        #1;
        chk("arb first grant", 64'(b4.ch_tx_ready), 64'b0001);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("arb word%0d", k), 64'(b4.to_host_dat), 64'(arb_exp[k]));
            chk($sformatf("arb valid%0d", k), 64'(b4.to_host_valid), 64'h1);
        end

        // Back-pressure: output held, no grants
        b4.to_host_ready = 1'b0;
        #1;
        chk("bp tx_ready", 64'(b4.ch_tx_ready), 64'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("bp hold dat%0d", k), 64'(b4.to_host_dat), 64'h00AA);
            chk($sformatf("bp hold tx_ready%0d", k), 64'(b4.ch_tx_ready), 64'h0);
        end
        b4.to_host_ready = 1'b1;
        #1;
        chk("bp resume grant", 64'(b4.ch_tx_ready), 64'b0010);
        step();
        chk("bp resume word", 64'(b4.to_host_dat), 64'h40AB);
        b4.ch_tx_valid = 4'h0;
        step();
        chk("tx drain valid", 64'(b4.to_host_valid), 64'h0);

        // Reset while words are held
        b4.from_host_dat = 16'h8123; b4.from_host_valid = 1'b1;
        b4.ch_tx_valid = 4'hF; b4.to_host_ready = 1'b0;
        step();
        b4.from_host_valid = 1'b0;
        chk("prereset rx held", 64'(b4.ch_rx_valid), 64'b0100);
        chk("prereset tx word", 64'(b4.to_host_dat), 64'h80AC);
        #2 clrn = 1'b0;
        #1;
        chk("midreset ch_rx_valid", 64'(b4.ch_rx_valid), 64'h0);
        chk("midreset to_host_valid", 64'(b4.to_host_valid), 64'h0);
        chk("midreset drop_count", 64'(b4.drop_count), 64'h0);
        chk("midreset drop_count n3", 64'(b3.drop_count), 64'h0);
        chk("midreset tx_ready", 64'(b4.ch_tx_ready), 64'h0);
        b4.to_host_ready = 1'b1;
        #2 clrn = 1'b1;
        #1;
        chk("postreset first grant", 64'(b4.ch_tx_ready), 64'b0001);
        step();
        chk("postreset first word", 64'(b4.to_host_dat), 64'h00AA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
